// File: rtl/nemesis_sound_debug_seq_if.sv
// nemesis_sound_debug_seq_if: debug sequencer bus; master drives button/volume/ack inputs, slave drives index, latch, irq, busy, channel enables and balance
interface nemesis_sound_debug_seq_if #(parameter int NCH = 4);
  logic i_next, i_prev, i_trig, i_auto, i_sound_ack;
  logic [NCH-1:0] i_ch_toggle;
  logic [4*NCH-1:0] i_vol;
  logic [4:0] o_cmd_idx;
  logic [7:0] o_sound_data;
  logic o_sound_irq, o_busy;
  logic [NCH-1:0] o_ch_on;
  logic [8*NCH-1:0] o_bal;
  modport master (output i_next, i_prev, i_trig, i_auto, i_sound_ack, i_ch_toggle, i_vol,
                  input o_cmd_idx, o_sound_data, o_sound_irq, o_busy, o_ch_on, o_bal);
  modport slave (input i_next, i_prev, i_trig, i_auto, i_sound_ack, i_ch_toggle, i_vol,
                 output o_cmd_idx, o_sound_data, o_sound_irq, o_busy, o_ch_on, o_bal);
endinterface

// File: rtl/nemesis_sound_debug_seq.sv
// nemesis_sound_debug_seq: steps/issues sound commands via latch+irq handshake, channel mute and balance; ports i_clk, i_reset (async high), bus (slave)
module nemesis_sound_debug_seq #(
  parameter int NCH = 4,
  parameter int NUM_CMDS = 25,
  parameter logic [8*NUM_CMDS-1:0] CMD_TABLE = {8'h0A,8'h35,8'h82,8'h00,8'h4A,8'h49,8'h48,8'h47,8'h46,8'h43,8'h45,8'h44,8'h42,
                                               8'h4B,8'h41,8'h40,8'h24,8'h0C,8'h08,8'h12,8'h1A,8'h03,8'h02,8'h01,8'h81},
  parameter logic [8*NCH-1:0] BAL_BASE = {8'd118,8'd86,8'd78,8'd78},
  parameter int BAL_STEP = 2,
  parameter int IRQ_TIMEOUT = 1024,
  parameter int GAP_CYCLES = 24000000
) (
  input logic i_clk,
  input logic i_reset,
  nemesis_sound_debug_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IRQ, GAP} state_t;
  state_t state;
  logic [31:0] timer;
  logic next_q, prev_q, trig_q, next_e, prev_e, trig_e;
  logic [NCH-1:0] tog_q;
  logic [4:0] idx_inc, idx_dec;
  logic [7:0] rom [32];
  logic [8*NCH-1:0] bal_n;
  logic [9:0] sum;
  for (genvar g = 0; g < 32; g++) begin : g_rom
    if (g < NUM_CMDS) begin : g_v
      assign rom[g] = CMD_TABLE[8*g +: 8];
    end else begin : g_z
      assign rom[g] = 8'h00;
    end
  end
  assign next_e = bus.i_next & ~next_q;
  assign prev_e = bus.i_prev & ~prev_q;
  assign trig_e = bus.i_trig & ~trig_q;
  assign idx_inc = bus.o_cmd_idx == 5'(NUM_CMDS - 1) ? 5'd0 : bus.o_cmd_idx + 5'd1;
  assign idx_dec = bus.o_cmd_idx == 5'd0 ? 5'(NUM_CMDS - 1) : bus.o_cmd_idx - 5'd1;
  always_comb begin
    bal_n = '0;
    sum = '0;
    for (int c = 0; c < NCH; c++) begin
      sum = 10'(BAL_BASE[8*c +: 8]) + 10'(BAL_STEP) * 10'(bus.i_vol[4*c +: 4]);
      bal_n[8*c +: 8] = sum > 10'd255 ? 8'hff : sum[7:0];
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      timer <= '0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
      trig_q <= 1'b0;
      bus.o_cmd_idx <= '0;
      bus.o_sound_data <= '0;
      bus.o_sound_irq <= 1'b0;
      bus.o_busy <= 1'b0;
    end else begin
      next_q <= bus.i_next;
      prev_q <= bus.i_prev;
      trig_q <= bus.i_trig;
      case (state)
        IDLE:
          if (trig_e || bus.i_auto) begin
            bus.o_sound_data <= rom[bus.o_cmd_idx];
            bus.o_sound_irq <= 1'b1;
            bus.o_busy <= 1'b1;
            timer <= '0;
            state <= IRQ;
          end else if (next_e != prev_e) begin
            bus.o_cmd_idx <= next_e ? idx_inc : idx_dec;
          end
        IRQ:
          if (bus.i_sound_ack || timer == 32'(IRQ_TIMEOUT - 1)) begin
            bus.o_sound_irq <= 1'b0;
            timer <= '0;
            state <= GAP;
          end else begin
            timer <= timer + 32'd1;
          end
        GAP:
          if (timer != 32'(GAP_CYCLES - 1)) begin
            timer <= timer + 32'd1;
          end else if (bus.i_auto) begin
            bus.o_cmd_idx <= idx_inc;
            bus.o_sound_data <= rom[idx_inc];
            bus.o_sound_irq <= 1'b1;
            timer <= '0;
            state <= IRQ;
          end else begin
            bus.o_busy <= 1'b0;
            timer <= '0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      tog_q <= '0;
      bus.o_ch_on <= '1;
      bus.o_bal <= BAL_BASE;
    end else begin
      tog_q <= bus.i_ch_toggle;
      bus.o_ch_on <= bus.o_ch_on ^ (bus.i_ch_toggle & ~tog_q);
      bus.o_bal <= bal_n;
    end
endmodule

// File: tb/tb_nemesis_sound_debug_seq.sv
// tb_nemesis_sound_debug_seq: random and directed stimulus checked against a behavioural model of the sequencer
module tb_nemesis_sound_debug_seq;
  localparam int NCH = 4;
  localparam int NUM_CMDS = 25;
  localparam int TO = 16;
  localparam int GAP = 8;
  localparam logic [8*NCH-1:0] BASE = {8'd118,8'd86,8'd78,8'd250};
  logic clk = 0;
  logic rst = 0;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  nemesis_sound_debug_seq_if #(.NCH(NCH)) bus();
  nemesis_sound_debug_seq #(.NCH(NCH), .BAL_BASE(BASE), .IRQ_TIMEOUT(TO), .GAP_CYCLES(GAP))
    dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  byte unsigned tbl [NUM_CMDS] = '{8'h81,8'h01,8'h02,8'h03,8'h1A,8'h12,8'h08,8'h0C,8'h24,8'h40,8'h41,8'h4B,8'h42,
                                   8'h44,8'h45,8'h43,8'h46,8'h47,8'h48,8'h49,8'h4A,8'h00,8'h82,8'h35,8'h0A};
  int m_idx, m_data, m_mode, m_left;
  int m_bal [NCH];
  bit m_irq, h_next, h_prev, h_trig;
  bit [NCH-1:0] m_on, h_tog;
  logic ne, pe, te;
  assign ne = bus.i_next & ~h_next;
  assign pe = bus.i_prev & ~h_prev;
  assign te = bus.i_trig & ~h_trig;
  function automatic int sat(input int v);
    return v > 255 ? 255 : v;
  endfunction
  function automatic logic [31:0] exp_bal();
    logic [31:0] r = '0;
    for (int c = 0; c < NCH; c++) r[8*c +: 8] = 8'(m_bal[c]);
    return r;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_idx <= 0;
      m_data <= 0;
      m_irq <= 0;
      m_mode <= 0;
      m_left <= 0;
      m_on <= '1;
      h_next <= 0;
      h_prev <= 0;
      h_trig <= 0;
      h_tog <= '0;
      for (int c = 0; c < NCH; c++) m_bal[c] <= int'(BASE[8*c +: 8]);
    end else begin
      h_next <= bus.i_next;
      h_prev <= bus.i_prev;
      h_trig <= bus.i_trig;
      h_tog <= bus.i_ch_toggle;
      m_on <= m_on ^ (bus.i_ch_toggle & ~h_tog);
      for (int c = 0; c < NCH; c++) m_bal[c] <= sat(int'(BASE[8*c +: 8]) + 2 * int'(bus.i_vol[4*c +: 4]));
      if (m_mode == 0) begin
        if (te || bus.i_auto) begin
          m_data <= tbl[m_idx];
          m_irq <= 1;
          m_left <= TO;
          m_mode <= 1;
        end else if (ne && !pe) m_idx <= (m_idx + 1) % NUM_CMDS;
        else if (pe && !ne) m_idx <= (m_idx + NUM_CMDS - 1) % NUM_CMDS;
      end else if (m_mode == 1) begin
        if (bus.i_sound_ack || m_left == 1) begin
          m_irq <= 0;
          m_left <= GAP;
          m_mode <= 2;
        end else m_left <= m_left - 1;
      end else begin
        if (m_left > 1) m_left <= m_left - 1;
        else if (bus.i_auto) begin
          m_idx <= (m_idx + 1) % NUM_CMDS;
          m_data <= tbl[(m_idx + 1) % NUM_CMDS];
          m_irq <= 1;
          m_left <= TO;
          m_mode <= 1;
        end else m_mode <= 0;
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("m_idx", 32'(bus.o_cmd_idx), 32'(m_idx));
      chk("m_data", 32'(bus.o_sound_data), 32'(m_data));
      chk("m_irq", 32'(bus.o_sound_irq), 32'(m_irq));
      chk("m_busy", 32'(bus.o_busy), 32'(m_mode != 0));
      chk("m_ch_on", 32'(bus.o_ch_on), 32'(m_on));
      chk("m_bal", 32'(bus.o_bal), exp_bal());
    end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200 && bus.o_busy; n++) tick(1);
    chk(tag, 32'(bus.o_busy), 0);
  endtask
  initial begin
    byte unsigned seen [$];
    int cnt;
    bit last;
    {bus.i_next, bus.i_prev, bus.i_trig, bus.i_auto, bus.i_sound_ack} = '0;
    bus.i_ch_toggle = '0;
    bus.i_vol = '0;
    #1 rst = 1;
    tick(2);
    chk("rst_idx", 32'(bus.o_cmd_idx), 0);
    chk("rst_data", 32'(bus.o_sound_data), 0);
    chk("rst_irq", 32'(bus.o_sound_irq), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_ch_on", 32'(bus.o_ch_on), 32'hf);
    chk("rst_bal", 32'(bus.o_bal), 32'(BASE));
    rst = 0;
    tick(1);
    bus.i_trig = 1;
    tick(1);
    bus.i_trig = 0;
    chk("trig_data", 32'(bus.o_sound_data), 32'h81);
    chk("trig_irq", 32'(bus.o_sound_irq), 1);
    chk("trig_busy", 32'(bus.o_busy), 1);
    tick(2);
    bus.i_sound_ack = 1;
    tick(1);
    bus.i_sound_ack = 0;
    chk("ack_irq", 32'(bus.o_sound_irq), 0);
    wait_idle("gap_idle");
    bus.i_prev = 1;
    tick(1);
    bus.i_prev = 0;
    chk("prev_wrap", 32'(bus.o_cmd_idx), 24);
    bus.i_trig = 1;
    tick(1);
    bus.i_trig = 0;
    chk("data_last", 32'(bus.o_sound_data), 32'h0A);
    bus.i_sound_ack = 1;
    tick(1);
    bus.i_sound_ack = 0;
    wait_idle("idle2");
    bus.i_next = 1;
    tick(1);
    bus.i_next = 0;
    chk("next_wrap", 32'(bus.o_cmd_idx), 0);
    tick(1);
    {bus.i_next, bus.i_prev} = 2'b11;
    tick(1);
    {bus.i_next, bus.i_prev} = 2'b00;
    chk("next_prev", 32'(bus.o_cmd_idx), 0);
    bus.i_trig = 1;
    tick(1);
    bus.i_trig = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_sound_irq) cnt++;
      bus.i_next = (i == 3);
      tick(1);
    end
    bus.i_next = 0;
    chk("timeout_len", 32'(cnt), TO);
    chk("busy_next", 32'(bus.o_cmd_idx), 0);
    bus.i_auto = 1;
    last = 0;
    for (int i = 0; i < 450; i++) begin
      if (bus.o_sound_irq && !last) seen.push_back(bus.o_sound_data);
      last = bus.o_sound_irq;
      bus.i_sound_ack = bus.o_sound_irq && ($urandom % 2 == 0);
      tick(1);
    end
    bus.i_sound_ack = 0;
    chk("auto_count", 32'(seen.size() > NUM_CMDS), 1);
    for (int k = 0; k < seen.size(); k++) chk("auto_seq", 32'(seen[k]), 32'(tbl[k % NUM_CMDS]));
    for (int n = 0; n < 100 && !(bus.o_busy && !bus.o_sound_irq); n++) tick(1);
    bus.i_auto = 0;
    cnt = 0;
    last = bus.o_sound_irq;
    for (int n = 0; n < 100 && bus.o_busy; n++) begin
      tick(1);
      if (bus.o_sound_irq && !last) cnt++;
      last = bus.o_sound_irq;
    end
    chk("auto_drop_idle", 32'(bus.o_busy), 0);
    chk("auto_drop_issue", 32'(cnt), 0);
    for (int i = 0; i < 3000; i++) begin
      bus.i_next = ($urandom % 6 == 0);
      bus.i_prev = ($urandom % 6 == 0);
      bus.i_trig = ($urandom % 12 == 0);
      bus.i_sound_ack = ($urandom % 4 == 0);
      bus.i_ch_toggle = NCH'($urandom & $urandom);
      if ($urandom % 8 == 0) bus.i_vol = 16'($urandom);
      if ($urandom % 150 == 0) bus.i_auto = ~bus.i_auto;
      tick(1);
    end
    {bus.i_next, bus.i_prev, bus.i_trig, bus.i_auto, bus.i_sound_ack} = '0;
    bus.i_ch_toggle = '0;
    wait_idle("rand_idle");
    bus.i_trig = 1;
    tick(1);
    bus.i_trig = 0;
    tick(2);
    #2 rst = 1;
    #1;
    chk("arst_irq", 32'(bus.o_sound_irq), 0);
    chk("arst_idx", 32'(bus.o_cmd_idx), 0);
    chk("arst_data", 32'(bus.o_sound_data), 0);
    chk("arst_busy", 32'(bus.o_busy), 0);
    tick(1);
    rst = 0;
    bus.i_vol = '0;
    bus.i_ch_toggle = 4'b0101;
    tick(1);
    chk("tog1", 32'(bus.o_ch_on), 32'hA);
    bus.i_ch_toggle = '0;
    tick(1);
    bus.i_ch_toggle = 4'b0101;
    tick(1);
    chk("tog2", 32'(bus.o_ch_on), 32'hF);
    bus.i_ch_toggle = '0;
    bus.i_vol = 16'hFFFF;
    tick(1);
    chk("bal_max", 32'(bus.o_bal), {8'd148, 8'd116, 8'd108, 8'd255});
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nemesis_sound_debug_seq.md
Name: nemesis_sound_debug_seq

Overview:
Parametrised, sequential successor to the combinational sound-debug lookup. It holds a selectable sound-command index and issues the selected command to the sound CPU with a latch + IRQ handshake. It can also step through all commands automatically. Per-channel mute mask and registered balance gains are generated for N channels. It sits between the debug OSD/button inputs and the sound board's command latch and mixer.

Parameters:
NCH, 4, number of mixer channels (default order: prom1, prom2, ay7, ay8)
NUM_CMDS, 25, number of valid command-table entries (max 32)
CMD_TABLE, {8'h0A,8'h35,8'h82,8'h00,8'h4A,8'h49,8'h48,8'h47,8'h46,8'h43,8'h45,8'h44,8'h42,8'h4B,8'h41,8'h40,8'h24,8'h0C,8'h08,8'h12,8'h1A,8'h03,8'h02,8'h01,8'h81}, packed 8-bit entries, entry 0 in bits [7:0]
BAL_BASE, {8'd118,8'd86,8'd78,8'd78}, packed 8-bit per-channel balance at vol=0, channel 0 in bits [7:0]
BAL_STEP, 2, balance increment per volume step
IRQ_TIMEOUT, 1024, max cycles IRQ held without ack (>=1)
GAP_CYCLES, 24000000, idle cycles between auto-mode commands (>=1)

Ports:
i_clk  in  1  system clock
i_reset  in  1  reset; asynchronous, active-high
i_next  in  1  level; rising edge advances index
i_prev  in  1  level; rising edge decrements index
i_trig  in  1  level; rising edge issues current command
i_auto  in  1  level; 1 = auto-cycle mode
i_ch_toggle  in  NCH  level per channel; rising edge toggles that channel's enable
i_vol  in  4*NCH  per-channel volume code 0..15
i_sound_ack  in  1  sound CPU has read the latch (1-cycle pulse or level)
o_cmd_idx  out  5  current command index
o_sound_data  out  8  command latch to sound CPU
o_sound_irq  out  1  interrupt request to sound CPU
o_busy  out  1  FSM not in IDLE
o_ch_on  out  NCH  channel enables
o_bal  out  8*NCH  per-channel balance, channel 0 in [7:0]

Behaviour:
- Reset values: o_cmd_idx=0, o_sound_data=0, o_sound_irq=0, o_busy=0, o_ch_on=all 1, o_bal[i]=BAL_BASE[i]. All edge-detect history registers = 0.
- Edge detection: register each level input; event = in & ~prev. A level high at reset release produces an edge on the first clock.
- Index, IDLE only. next: idx==NUM_CMDS-1 ? 0 : idx+1. prev: idx==0 ? NUM_CMDS-1 : idx-1. next and prev in the same cycle: no change. Edges outside IDLE are dropped, not queued.
- FSM states:
  - IDLE: trig edge or i_auto=1 -> o_sound_data<=CMD_TABLE[idx], o_sound_irq<=1, timer<=0 -> IRQ. Trig has priority over next/prev in the same cycle; the index is unchanged.
  - IRQ: i_sound_ack or timer==IRQ_TIMEOUT-1 -> o_sound_irq<=0, timer<=0 -> GAP. Otherwise timer++. Ack arriving on the same cycle as the timeout counts as an ack; the result is identical.
  - GAP: timer==GAP_CYCLES-1 -> if i_auto: idx advances with wrap, o_sound_data<=CMD_TABLE[new idx], o_sound_irq<=1 -> IRQ; else -> IDLE. Otherwise timer++.
- Latency: o_sound_irq and o_sound_data update 1 cycle after the trig edge is registered. o_sound_data holds its value until the next issue.
- o_busy = (state != IDLE), registered alongside state.
- i_auto dropped mid-IRQ/GAP: the current sequence completes, then the FSM returns to IDLE.
- Channel mask: o_ch_on[i] toggles on each rising edge of i_ch_toggle[i]. Independent of FSM state, 1-cycle latency after the edge register. Simultaneous toggles on several bits all apply.
- Balance: o_bal[i] <= min(255, BAL_BASE[i] + BAL_STEP*i_vol[i]), registered with 1-cycle latency. Computed in 10-bit width, then saturated.
- Reset asserted mid-operation: all state and outputs return immediately to reset values; any IRQ is withdrawn asynchronously.

Test Plan:
- Reset, then pulse i_trig at idx 0 -> after 1 cycle o_sound_data=8'h81, o_sound_irq=1, o_busy=1. Ack 3 cycles later -> irq=0 next cycle. After GAP_CYCLES (bench override 8) -> o_busy=0.
- From idx 0, pulse i_prev -> o_cmd_idx=24. Trig -> o_sound_data=8'h0A. Pulse i_next -> idx=0. Next+prev same cycle -> idx unchanged.
- Trig with no ack, IRQ_TIMEOUT=16 -> o_sound_irq high exactly 16 cycles, then low. next edge during busy -> idx unchanged.
- i_auto=1, GAP_CYCLES=8, ack each IRQ -> data sequence 81,01,02,03… wrapping 0A->81. Drop i_auto mid-GAP -> returns IDLE without a further issue.
- i_ch_toggle=4'b0101 edge -> o_ch_on=4'b1010. Second edge -> 4'b1111.
- i_vol all 15 -> o_bal={148,116,108,108}. Override BAL_BASE[0]=250 -> o_bal[7:0]=255 (saturated). Assert reset mid-IRQ -> irq=0, idx=0, data=0 immediately.
